regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the register data width.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning asynchronous, active-low reset.
REQ-004 The block SHALL have port clr_req, input, 1, meaning a request to start the zero-clear sweep of registers 1..31.
REQ-005 The block SHALL have port clr_busy, output, 1, meaning the clear sweep is in progress.
REQ-006 The block SHALL have ports a_valid, input, 1; a_addr, input, 5; a_data, input, DATA_WIDTH, meaning requester A (ALU writeback) write request.
REQ-007 The block SHALL have port a_ready, output, 1, meaning requester A's request is accepted this cycle.
REQ-008 The block SHALL have ports b_valid, input, 1; b_addr, input, 5; b_data, input, DATA_WIDTH, meaning requester B (load/syscall writeback) write request.
REQ-009 The block SHALL have port b_ready, output, 1, meaning requester B's request is accepted this cycle.
REQ-010 The block SHALL have ports rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, DATA_WIDTH, all registered, driving the regfile single write port.

Function
REQ-011 The FSM SHALL have two states: IDLE (arbitrate requesters) and CLEAR (sweep).
REQ-012 A transfer SHALL occur when x_valid && x_ready; at most one transfer per cycle.
REQ-013 In IDLE, a_ready and b_ready SHALL be combinational from valids, the priority pointer and clr_req; ready SHALL NOT depend on the requester's own data or addr.
REQ-014 In IDLE with exactly one valid requester and clr_req low, that requester's ready SHALL be 1.
REQ-015 In IDLE with both valid, the requester named by the 1-bit round-robin pointer SHALL be granted; the pointer SHALL then point to the other requester.
REQ-016 When a single requester is granted without contention, the pointer SHALL point to the other requester.
REQ-017 A transfer in cycle N SHALL produce rf_we=1, rf_waddr=addr, rf_wdata=data in cycle N+1 (latency 1).
REQ-018 A transfer with addr 0 SHALL be accepted (ready=1) but SHALL produce rf_we=0 in cycle N+1.
REQ-019 With no transfer and not in CLEAR, rf_we SHALL be 0 in the next cycle; rf_waddr and rf_wdata SHALL hold their previous values.
REQ-020 In IDLE, clr_req=1 SHALL take precedence over requesters: both readys 0 that cycle, next state CLEAR, sweep counter loaded with 1.
REQ-021 In CLEAR, each cycle SHALL register rf_we=1, rf_waddr=counter, rf_wdata=0, then increment the counter; both readys SHALL be 0.
REQ-022 After issuing address 31, the FSM SHALL return to IDLE; the sweep SHALL take exactly 31 cycles.
REQ-023 clr_busy SHALL be 1 exactly while the state is CLEAR; clr_req in CLEAR SHALL be ignored (no restart).
REQ-024 The counter SHALL be 5 bits; it SHALL NOT wrap to 0 within a sweep.

Reset
REQ-025 On rst low, asynchronously: state=IDLE, pointer=A, counter=0, rf_we=0, rf_waddr=0, rf_wdata=0, clr_busy=0; a_ready/b_ready SHALL be 0 while rst is low.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no further writes; the sweep SHALL NOT resume after release.

Structure
REQ-027 The register-count constant (32), zero-register index (0) and FSM state encodings SHALL live in the shared defines header.
REQ-028 The two-input round-robin grant SHALL be a sub-module rr_arb2 (req[1:0], pointer update, grant[1:0]).

Verification
REQ-029 A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-030 Both valid for 4 cycles after reset (A addr 3, B addr 4) -> grants in order A,B,A,B; rf_waddr sequence 3,4,3,4.
REQ-031 A with a_addr=0, a_data=0x1 -> a_ready=1, next cycle rf_we=0.
REQ-032 clr_req=1 while a_valid=1 -> a_ready=0; 31 cycles of rf_we=1, rf_waddr 1..31, rf_wdata=0; clr_busy=1 throughout; then IDLE, a_ready=1.
REQ-033 rst low at sweep address 10 -> rf_we=0 immediately, clr_busy=0; after release no writes without new requests.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and state encodings for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int         NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Round-robin pointer values: which requester wins a tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the loser after every grant.
module rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = (ptr_q == PTR_B) ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (grant_o[0])      ptr_d = PTR_B;
    else if (grant_o[1]) ptr_d = PTR_A;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= PTR_A;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two writeback requesters onto the single regfile write port and
// runs a zero-clear sweep of registers 1..31 on request.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic                  a_valid,
  input  logic [4:0]            a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [4:0]            b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  arb_open;
  logic [1:0]            req, grant;

  // Requests only reach the arbiter when a grant can actually be a transfer,
  // so the pointer never advances on a refused request.
  assign arb_open = (state_q == ST_IDLE) && !clr_req && rst;
  assign req      = {b_valid, a_valid} & {2{arb_open}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .grant_o (grant)
  );

  assign a_ready  = grant[0];
  assign b_ready  = grant[1];
  assign clr_busy = (state_q == ST_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = 5'd1;
        end else if (grant[0]) begin
          we_d    = (a_addr != ZERO_REG);
          waddr_d = a_addr;
          wdata_d = a_data;
        end else if (grant[1]) begin
          we_d    = (b_addr != ZERO_REG);
          waddr_d = b_addr;
          wdata_d = b_data;
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = '0;
        if (cnt_q == LAST_REG) begin
          state_d = ST_IDLE;
          cnt_d   = 5'd0;
        end else begin
          cnt_d   = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, sweep/reset sequences, random vs. model.
module tb_regfile_wb_arbiter;

  logic        clk, rst, clr_req, clr_busy;
  logic        a_valid, a_ready, b_valid, b_ready, rf_we;
  logic [4:0]  a_addr, b_addr, rf_waddr;
  logic [31:0] a_data, b_data, rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic clr);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    clr_req = clr;
  endtask

  typedef struct {
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic bv; logic [4:0] ba; logic [31:0] bd;
    logic clr;
    logic ear; logic ebr; logic ewe; logic [4:0] ewa; logic [31:0] ewd;
    logic chk_wr;
  } vec_t;

  vec_t tbl[10];

  // Reference model state: sweep progress, tie pointer, expected write port.
  bit          m_sweeping;
  int          m_swaddr;
  bit          m_ptr_b;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    m_sweeping = 0; m_swaddr = 0; m_ptr_b = 0;
    m_we = 0; m_wa = 0; m_wd = 0;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 5'd5, 32'h1234, 1, 5'd6, 32'h5678, 0);
    #2;
    chk("reset_a_ready", {31'b0, a_ready}, 32'd0);
    chk("reset_b_ready", {31'b0, b_ready}, 32'd0);
    chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
    chk("reset_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_clr_busy", {31'b0, clr_busy}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // ---- directed vectors, right after reset (pointer at A) ----
    tbl[0] = '{1, 5'd3, 32'h11110003, 1, 5'd4, 32'h22220004, 0, 1, 0, 1, 5'd3, 32'h11110003, 1};
    tbl[1] = '{1, 5'd3, 32'h11110003, 1, 5'd4, 32'h22220004, 0, 0, 1, 1, 5'd4, 32'h22220004, 1};
    tbl[2] = '{1, 5'd3, 32'h11110003, 1, 5'd4, 32'h22220004, 0, 1, 0, 1, 5'd3, 32'h11110003, 1};
    tbl[3] = '{1, 5'd3, 32'h11110003, 1, 5'd4, 32'h22220004, 0, 0, 1, 1, 5'd4, 32'h22220004, 1};
    tbl[4] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 1};
    tbl[5] = '{0, 5'd9, 32'hAAAA0000, 0, 5'd8, 32'hBBBB0000, 0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 1};
    tbl[6] = '{1, 5'd0, 32'h00000001, 0, 5'd0, 32'h0,        0, 1, 0, 0, 5'd0, 32'h0,        0};
    tbl[7] = '{0, 5'd0, 32'h0,        1, 5'd7, 32'h00000077, 0, 0, 1, 1, 5'd7, 32'h00000077, 1};
    tbl[8] = '{1, 5'd9, 32'h00000099, 1, 5'd10, 32'h000000AA, 0, 1, 0, 1, 5'd9, 32'h00000099, 1};
    tbl[9] = '{0, 5'd0, 32'h0,        1, 5'd11, 32'h000000BB, 0, 0, 1, 1, 5'd11, 32'h000000BB, 1};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd, tbl[i].clr);
      #1;
      chk($sformatf("vec%0d_a_ready", i), {31'b0, a_ready}, {31'b0, tbl[i].ear});
      chk($sformatf("vec%0d_b_ready", i), {31'b0, b_ready}, {31'b0, tbl[i].ebr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rf_we", i), {31'b0, rf_we}, {31'b0, tbl[i].ewe});
      if (tbl[i].chk_wr) begin
        chk($sformatf("vec%0d_rf_waddr", i), {27'b0, rf_waddr}, {27'b0, tbl[i].ewa});
        chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, tbl[i].ewd);
      end
    end

    // ---- full sweep with A waiting, clr_req re-asserted mid-sweep ----
    @(negedge clk);
    drive(1, 5'd12, 32'hC0FFEE00, 0, 0, 0, 1);
    #1;
    chk("sweep_start_a_ready", {31'b0, a_ready}, 32'd0);
    @(posedge clk);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      clr_req = (k == 15);
      #1;
      chk($sformatf("sweep%0d_busy", k), {31'b0, clr_busy}, 32'd1);
      chk($sformatf("sweep%0d_a_ready", k), {31'b0, a_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("sweep%0d_rf_we", k), {31'b0, rf_we}, 32'd1);
      chk($sformatf("sweep%0d_rf_waddr", k), {27'b0, rf_waddr}, k);
      chk($sformatf("sweep%0d_rf_wdata", k), rf_wdata, 32'd0);
    end
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    chk("sweep_end_busy", {31'b0, clr_busy}, 32'd0);
    chk("sweep_end_a_ready", {31'b0, a_ready}, 32'd1);
    @(posedge clk); #1;
    chk("sweep_end_rf_waddr", {27'b0, rf_waddr}, 32'd12);
    chk("sweep_end_rf_wdata", rf_wdata, 32'hC0FFEE00);

    // ---- reset in the middle of a sweep ----
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_pre_rf_waddr", {27'b0, rf_waddr}, 32'd10);
    rst = 1'b0;
    a_valid = 1'b1;
    #1;
    chk("abort_rf_we", {31'b0, rf_we}, 32'd0);
    chk("abort_busy", {31'b0, clr_busy}, 32'd0);
    chk("abort_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("abort_a_ready", {31'b0, a_ready}, 32'd0);
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_post%0d_rf_we", k), {31'b0, rf_we}, 32'd0);
      chk($sformatf("abort_post%0d_busy", k), {31'b0, clr_busy}, 32'd0);
    end

    // ---- random traffic against the reference model ----
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic av, bv, clr, ear, ebr;
      logic [4:0] aa, ba;
      logic [31:0] ad, bd;
      @(negedge clk);
      av  = ($urandom_range(0, 1) == 1);
      bv  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 49) == 0);
      aa  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ba  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ad  = $urandom;
      bd  = $urandom;
      drive(av, aa, ad, bv, ba, bd, clr);

      if (m_sweeping || clr) begin
        ear = 0; ebr = 0;
      end else if (av && bv) begin
        ear = !m_ptr_b; ebr = m_ptr_b;
      end else begin
        ear = av; ebr = bv;
      end
      #1;
      chk("rand_a_ready", {31'b0, a_ready}, {31'b0, ear});
      chk("rand_b_ready", {31'b0, b_ready}, {31'b0, ebr});
      chk("rand_clr_busy", {31'b0, clr_busy}, {31'b0, logic'(m_sweeping)});

      if (m_sweeping) begin
        m_we = 1; m_wa = 5'(m_swaddr); m_wd = 0;
        m_swaddr++;
        if (m_swaddr == 32) m_sweeping = 0;
      end else if (clr) begin
        m_sweeping = 1; m_swaddr = 1; m_we = 0;
      end else if (ear) begin
        m_we = (aa != 0);
        if (m_we) begin m_wa = aa; m_wd = ad; end
        m_ptr_b = 1;
      end else if (ebr) begin
        m_we = (ba != 0);
        if (m_we) begin m_wa = ba; m_wd = bd; end
        m_ptr_b = 0;
      end else begin
        m_we = 0;
      end

      @(posedge clk); #1;
      chk("rand_rf_we", {31'b0, rf_we}, {31'b0, m_we});
      if (m_we) begin
        chk("rand_rf_waddr", {27'b0, rf_waddr}, {27'b0, m_wa});
        chk("rand_rf_wdata", rf_wdata, m_wd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
